// File: rtl/clahe_tile_sched_if.sv
// Pixel-stream qualifiers, per-pixel coordinates and the CDF engine handshake of the CLAHE tile scheduler.
// master is the scheduler side, slave is the surrounding pipeline / CDF engine.
interface clahe_tile_sched_if #(
    parameter int IMG_W  = 1024,
    parameter int IMG_H  = 768,
    parameter int TILE_W = 128,
    parameter int TILE_H = 96
);
    localparam int TILES_X = IMG_W / TILE_W;
    localparam int TILES_Y = IMG_H / TILE_H;
    localparam int NT      = TILES_X * TILES_Y;
    localparam int XW      = (IMG_W > 1)   ? $clog2(IMG_W)   : 1;
    localparam int YW      = (IMG_H > 1)   ? $clog2(IMG_H)   : 1;
    localparam int CW      = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int RW      = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int TW      = (NT > 1)      ? $clog2(NT)      : 1;

    logic          in_V_SYNC;
    logic          in_data_en;
    logic          TVALID_in;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] tile_col;
    logic [RW-1:0] tile_row;
    logic [TW-1:0] tile_idx;
    logic          hist_bank;
    logic          cdf_req;
    logic [TW-1:0] cdf_tile;
    logic          cdf_bank;
    logic          cdf_ack;
    logic          cdf_done;
    logic          frame_err;
    logic          ovr_err;

    modport master (
        input  in_V_SYNC, in_data_en, TVALID_in, cdf_ack,
        output pix_valid, pix_x, pix_y, tile_col, tile_row, tile_idx,
               hist_bank, cdf_req, cdf_tile, cdf_bank, cdf_done, frame_err, ovr_err
    );

    modport slave (
        output in_V_SYNC, in_data_en, TVALID_in, cdf_ack,
        input  pix_valid, pix_x, pix_y, tile_col, tile_row, tile_idx,
               hist_bank, cdf_req, cdf_tile, cdf_bank, cdf_done, frame_err, ovr_err
    );
endinterface

// File: rtl/clahe_tile_sched.sv
// Frame/tile scheduler: registered pixel coordinates and tile ownership (1 cycle), ping-pong bank select.
// Pixels are never stalled; the CDF engine is paced by cdf_req held until cdf_ack, one tile per ack.
module clahe_tile_sched #(
    parameter int IMG_W  = 1024,
    parameter int IMG_H  = 768,
    parameter int TILE_W = 128,
    parameter int TILE_H = 96
) (
    input  logic               clk,
    input  logic               rst_n,
    clahe_tile_sched_if.master bus
);
    localparam int TILES_X = IMG_W / TILE_W;
    localparam int TILES_Y = IMG_H / TILE_H;
    localparam int NT      = TILES_X * TILES_Y;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int XW      = (IMG_W > 1)   ? $clog2(IMG_W)   : 1;
    localparam int YW      = (IMG_H > 1)   ? $clog2(IMG_H)   : 1;
    localparam int SXW     = (TILE_W > 1)  ? $clog2(TILE_W)  : 1;
    localparam int SYW     = (TILE_H > 1)  ? $clog2(TILE_H)  : 1;
    localparam int CW      = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int RW      = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int TW      = (NT > 1)      ? $clog2(NT)      : 1;
    localparam int PCW     = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, CDF} state_t;

    state_t          state, state_nxt;
    logic            vs_d;
    logic            rise, fall, accept, frame_full, frame_ok, last_tile, cdf_step;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [SXW-1:0]  sub_x;
    logic [SYW-1:0]  sub_y;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [TW-1:0]   tidx;
    logic [PCW-1:0]  pix_cnt;
    logic            long_frame;
    logic            pix_valid_q;
    logic [XW-1:0]   pix_x_q;
    logic [YW-1:0]   pix_y_q;
    logic [CW-1:0]   tile_col_q;
    logic [RW-1:0]   tile_row_q;
    logic [TW-1:0]   tile_idx_q;
    logic            hist_bank_q;
    logic [TW-1:0]   cdf_tile_q;
    logic            cdf_done_q;
    logic            frame_err_q;
    logic            ovr_err_q;

    assign rise       = bus.in_V_SYNC & ~vs_d;
    assign fall       = ~bus.in_V_SYNC & vs_d;
    assign accept     = (state == ACTIVE) & bus.in_V_SYNC & bus.in_data_en & bus.TVALID_in;
    assign frame_full = (pix_cnt == PCW'(NPIX));
    assign frame_ok   = frame_full & ~long_frame;
    assign last_tile  = (cdf_tile_q == TW'(NT - 1));
    assign cdf_step   = (state == CDF) & bus.cdf_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = ACTIVE;
            ACTIVE:  if (fall) state_nxt = frame_ok ? CDF : IDLE;
            CDF:     if (cdf_step && last_tile) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= 1'b0;
            x           <= '0;
            y           <= '0;
            sub_x       <= '0;
            sub_y       <= '0;
            col         <= '0;
            row         <= '0;
            tidx        <= '0;
            pix_cnt     <= '0;
            long_frame  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            tile_col_q  <= '0;
            tile_row_q  <= '0;
            tile_idx_q  <= '0;
            hist_bank_q <= 1'b0;
            cdf_tile_q  <= '0;
            cdf_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            vs_d        <= bus.in_V_SYNC;
            pix_valid_q <= 1'b0;
            cdf_done_q  <= 1'b0;

            if (state == IDLE && rise) begin
                x          <= '0;
                y          <= '0;
                sub_x      <= '0;
                sub_y      <= '0;
                col        <= '0;
                row        <= '0;
                tidx       <= '0;
                pix_cnt    <= '0;
                long_frame <= 1'b0;
            end

            if (accept) begin
                if (frame_full) begin
                    long_frame <= 1'b1;
                end else begin
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= x;
                    pix_y_q     <= y;
                    tile_col_q  <= col;
                    tile_row_q  <= row;
                    tile_idx_q  <= tidx;
                    pix_cnt     <= pix_cnt + 1'b1;
                    if (x == XW'(IMG_W - 1)) begin
                        // End of line: the tile index returns to the row start, or moves to the next row.
                        x     <= '0;
                        sub_x <= '0;
                        col   <= '0;
                        y     <= y + 1'b1;
                        if (sub_y == SYW'(TILE_H - 1)) begin
                            sub_y <= '0;
                            row   <= row + 1'b1;
                            tidx  <= tidx + 1'b1;
                        end else begin
                            sub_y <= sub_y + 1'b1;
                            tidx  <= tidx - TW'(TILES_X - 1);
                        end
                    end else begin
                        x <= x + 1'b1;
                        if (sub_x == SXW'(TILE_W - 1)) begin
                            sub_x <= '0;
                            col   <= col + 1'b1;
                            tidx  <= tidx + 1'b1;
                        end else begin
                            sub_x <= sub_x + 1'b1;
                        end
                    end
                end
            end

            if (state == ACTIVE && fall) begin
                if (frame_ok) begin
                    hist_bank_q <= ~hist_bank_q;
                    cdf_tile_q  <= '0;
                end else begin
                    frame_err_q <= 1'b1;
                end
            end

            if (cdf_step) begin
                if (last_tile) cdf_done_q <= 1'b1;
                else           cdf_tile_q <= cdf_tile_q + 1'b1;
            end

            // A new frame arriving while the CDF engine still owns the other bank is an overrun.
            if (state == CDF && rise) ovr_err_q <= 1'b1;
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.tile_col  = tile_col_q;
    assign bus.tile_row  = tile_row_q;
    assign bus.tile_idx  = tile_idx_q;
    assign bus.hist_bank = hist_bank_q;
    assign bus.cdf_bank  = ~hist_bank_q;
    assign bus.cdf_req   = (state == CDF);
    assign bus.cdf_tile  = cdf_tile_q;
    assign bus.cdf_done  = cdf_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.ovr_err   = ovr_err_q;
endmodule

// File: tb/tb_clahe_tile_sched.sv
// Directed bench for clahe_tile_sched in an 8x4 image of 4x2 tiles: frame table plus overrun and reset sequences.
module tb_clahe_tile_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   strobes;

    always #5 clk = ~clk;

    clahe_tile_sched_if #(.IMG_W(8), .IMG_H(4), .TILE_W(4), .TILE_H(2)) bus ();

    clahe_tile_sched #(.IMG_W(8), .IMG_H(4), .TILE_W(4), .TILE_H(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int npix;
        bit tv_half;
        int exp_strobes;
        bit exp_ferr;
        bit exp_bank;
        bit exp_req;
    } frame_vec_t;

    frame_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; every pix_valid strobe is compared with the raster position implied by its ordinal.
    task automatic tick();
        int n;
        @(posedge clk);
        #1;
        if (bus.pix_valid === 1'b1) begin
            n = strobes;
            check("pix_x", 32'(bus.pix_x), n % 8);
            check("pix_y", 32'(bus.pix_y), n / 8);
            check("tile_col", 32'(bus.tile_col), (n % 8) / 4);
            check("tile_row", 32'(bus.tile_row), (n / 8) / 2);
            check("tile_idx", 32'(bus.tile_idx), ((n / 8) / 2) * 2 + (n % 8) / 4);
            strobes++;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_pix_valid", 32'(bus.pix_valid), 0);
        check("rst_pix_x", 32'(bus.pix_x), 0);
        check("rst_pix_y", 32'(bus.pix_y), 0);
        check("rst_tile_col", 32'(bus.tile_col), 0);
        check("rst_tile_row", 32'(bus.tile_row), 0);
        check("rst_tile_idx", 32'(bus.tile_idx), 0);
        check("rst_hist_bank", 32'(bus.hist_bank), 0);
        check("rst_cdf_bank", 32'(bus.cdf_bank), 1);
        check("rst_cdf_req", 32'(bus.cdf_req), 0);
        check("rst_cdf_tile", 32'(bus.cdf_tile), 0);
        check("rst_cdf_done", 32'(bus.cdf_done), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_ovr_err", 32'(bus.ovr_err), 0);
    endtask

    // Rise cycle with no valid, then npix accepted pixels, then the fall cycle.
    task automatic do_frame(input int npix, input bit tv_half);
        int acc = 0;
        bit phase = 1'b1;
        strobes = 0;
        bus.in_V_SYNC  = 1'b1;
        bus.in_data_en = 1'b1;
        bus.TVALID_in  = 1'b0;
        tick();
        while (acc < npix) begin
            bus.TVALID_in = tv_half ? phase : 1'b1;
            if (bus.TVALID_in) acc++;
            phase = ~phase;
            tick();
        end
        bus.in_V_SYNC  = 1'b0;
        bus.in_data_en = 1'b0;
        bus.TVALID_in  = 1'b0;
        tick();
    endtask

    // Acks tiles first..3; even tiles acked at once, odd tiles after gap_odd stall cycles.
    task automatic run_cdf(input int first, input int gap_odd);
        for (int t = first; t < 4; t++) begin
            check("cdf_req_hold", 32'(bus.cdf_req), 1);
            check("cdf_tile_step", 32'(bus.cdf_tile), t);
            check("cdf_done_early", 32'(bus.cdf_done), 0);
            if ((t % 2) == 1) begin
                for (int g = 0; g < gap_odd; g++) begin
                    tick();
                    check("cdf_tile_stall", 32'(bus.cdf_tile), t);
                end
            end
            bus.cdf_ack = 1'b1;
            tick();
            bus.cdf_ack = 1'b0;
        end
        check("cdf_done_pulse", 32'(bus.cdf_done), 1);
        check("cdf_req_drop", 32'(bus.cdf_req), 0);
        bus.cdf_ack = 1'b1;
        tick();
        check("cdf_done_single", 32'(bus.cdf_done), 0);
        tick();
        bus.cdf_ack = 1'b0;
        check("stray_ack_req", 32'(bus.cdf_req), 0);
        check("stray_ack_done", 32'(bus.cdf_done), 0);
    endtask

    initial begin
        vecs[0] = '{32, 1'b0, 32, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32, 1'b1, 32, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{30, 1'b0, 30, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32, 1'b0, 32, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{33, 1'b0, 32, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32, 1'b1, 32, 1'b1, 1'b0, 1'b1};

        rst_n          = 1'b0;
        bus.in_V_SYNC  = 1'b0;
        bus.in_data_en = 1'b0;
        bus.TVALID_in  = 1'b0;
        bus.cdf_ack    = 1'b0;
        strobes        = 0;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            do_frame(vecs[i].npix, vecs[i].tv_half);
            check("frame_strobes", 32'(strobes), 32'(vecs[i].exp_strobes));
            check("frame_err", 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
            check("hist_bank", 32'(bus.hist_bank), 32'(vecs[i].exp_bank));
            check("cdf_bank", 32'(bus.cdf_bank), 32'(!vecs[i].exp_bank));
            check("cdf_req_after_fall", 32'(bus.cdf_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                run_cdf(0, 3);
            end else begin
                repeat (3) tick();
                check("no_cdf_req", 32'(bus.cdf_req), 0);
            end
        end

        // Overrun: a frame starts while tile 1 is waiting for its ack.
        do_frame(32, 1'b0);
        check("ovr_setup_bank", 32'(bus.hist_bank), 1);
        bus.cdf_ack = 1'b1;
        tick();
        bus.cdf_ack = 1'b0;
        check("ovr_setup_tile", 32'(bus.cdf_tile), 1);
        check("ovr_before", 32'(bus.ovr_err), 0);
        strobes        = 0;
        bus.in_V_SYNC  = 1'b1;
        bus.in_data_en = 1'b1;
        bus.TVALID_in  = 1'b1;
        tick();
        check("ovr_err_set", 32'(bus.ovr_err), 1);
        repeat (3) tick();
        check("ovr_tile_stalled", 32'(bus.cdf_tile), 1);
        run_cdf(1, 0);
        repeat (4) tick();
        bus.in_V_SYNC  = 1'b0;
        bus.in_data_en = 1'b0;
        bus.TVALID_in  = 1'b0;
        repeat (2) tick();
        check("ovr_no_strobes", 32'(strobes), 0);
        check("ovr_bank_kept", 32'(bus.hist_bank), 1);
        check("ovr_err_sticky", 32'(bus.ovr_err), 1);
        check("ferr_sticky", 32'(bus.frame_err), 1);

        // Reset while the CDF engine is on tile 2.
        do_frame(32, 1'b0);
        run_cdf(0, 0);
        do_frame(32, 1'b0);
        check("pre_rst_bank", 32'(bus.hist_bank), 1);
        bus.cdf_ack = 1'b1;
        tick();
        tick();
        bus.cdf_ack = 1'b0;
        check("pre_rst_tile", 32'(bus.cdf_tile), 2);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        tick();
        rst_n = 1'b1;
        tick();
        do_frame(32, 1'b0);
        check("post_rst_strobes", 32'(strobes), 32);
        check("post_rst_bank", 32'(bus.hist_bank), 1);
        check("post_rst_req", 32'(bus.cdf_req), 1);
        run_cdf(0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
